// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ
// byte requesters. A granted byte is captured, tx_start is pulsed once, and
// no further grant is issued until the transmitter reports tx_done.
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// abandons a frame after TIMEOUT_CYCLES cycles without tx_done and pulses
// timeout_err; without it WAIT waits indefinitely and timeout_err is tied 0.
module uart_tx_arbiter #(
  parameter int          N_REQ          = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [7:0]      req_byte [N_REQ];
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] next_ptr;
  logic            grant_fire;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]     wd_cnt;
`else
  logic            unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  // Split the flat requester data bus into one byte per requester
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin search from ptr upward with wrap; first valid index wins
  always_comb begin
    int              cand;
    int              nxt;
    logic [ID_W-1:0] cand_idx;
    cand        = 0;
    nxt         = 0;
    cand_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = ID_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    nxt = int'(grant_idx) + 1;
    if (nxt >= N_REQ) begin
      nxt = 0;
    end
    next_ptr = ID_W'(nxt);
  end

  assign grant_fire = enable && grant_found && !tx_busy;

  // Grant/launch/wait sequencer; all outputs are registered here
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      grant_id  <= '0;
      busy      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      tx_start  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_fire) begin
            state                <= LAUNCH;
            ptr                  <= next_ptr;
            tx_data              <= req_byte[grant_idx];
            grant_id             <= grant_idx;
            req_ready[grant_idx] <= 1'b1;
            tx_start             <= 1'b1;
            busy                 <= 1'b1;
          end
        end
        LAUNCH: begin
          // tx_done is deliberately not looked at here
          state <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wd_cnt == TIMEOUT_CYCLES - 16'd1) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester queues drive the byte handshake,
// a scoreboard of expected grants is checked whenever tx_start fires, and
// directed scenarios cover latency, round-robin order, blocking, event
// collisions, mid-frame reset and (when UART_ARB_TIMEOUT_EN is set) timeout.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           pclk = 1'b0;
  logic           rst;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       expQ [$];
  logic [7:0] pendByte [N][16];
  int         pendHead [N];
  int         pendTail [N];

  int checks     = 0;
  int errors     = 0;
  int cycleCnt   = 0;
  int lastStart  = -1;
  bit spacingOn  = 1'b0;
  bit prevStart  = 1'b0;
  bit autoDone   = 1'b0;
  int doneDelay  = 0;
  int doneCnt    = 0;

  // Free-running clock
  always #5 pclk = ~pclk;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (16'd50)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Cycle counter used to measure spacing between start pulses
  always @(posedge pclk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic refreshReq();
    for (int i = 0; i < N; i++) begin
      if (pendHead[i] != pendTail[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = pendByte[i][pendHead[i]];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic expectGrant(input int idx, input logic [7:0] b);
    exp_t e;
    e.id   = 2'(idx);
    e.data = b;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] b, input bit expectIt);
    pendByte[idx][pendTail[idx]] = b;
    pendTail[idx]++;
    if (expectIt) expectGrant(idx, b);
    refreshReq();
  endtask

  // Advance to the next falling edge and play the requester/transmitter side
  task automatic tick();
    @(negedge pclk);
    tx_done = 1'b0;
    if (autoDone && doneCnt > 0) begin
      doneCnt--;
      if (doneCnt == 0) tx_done = 1'b1;
    end
    if (autoDone && tx_start) doneCnt = doneDelay;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && pendHead[i] != pendTail[i]) pendHead[i]++;
    end
    refreshReq();
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    enable    = 1'b1;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    autoDone  = 1'b0;
    doneCnt   = 0;
    spacingOn = 1'b0;
    for (int i = 0; i < N; i++) begin
      pendHead[i] = 0;
      pendTail[i] = 0;
    end
    refreshReq();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    for (int c = 0; c < maxCycles; c++) begin
      if (expQ.size() == 0 && !busy && !tx_start) break;
      tick();
    end
    checkOutput("drain_queue", expQ.size(), 0);
    checkOutput("drain_busy", busy, 0);
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_req_ready"}, req_ready, 0);
    checkOutput({pfx, "_tx_start"}, tx_start, 0);
    checkOutput({pfx, "_tx_data"}, tx_data, 8'h00);
    checkOutput({pfx, "_grant_id"}, grant_id, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_timeout_err"}, timeout_err, 0);
  endtask

  // Scoreboard: every start pulse must match the oldest expected grant
  always @(negedge pclk) begin
    exp_t e;
    if (!rst) begin
      if (tx_start) begin
        checkOutput("sb_start_expected", (expQ.size() > 0), 1);
        checkOutput("sb_start_width", prevStart, 0);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("sb_grant_id", grant_id, e.id);
          checkOutput("sb_tx_data", tx_data, e.data);
          checkOutput("sb_req_ready", req_ready, 32'(1) << e.id);
        end
        if (spacingOn && lastStart >= 0)
          checkOutput("sb_start_gap", cycleCnt - lastStart, doneDelay + 2);
        lastStart = cycleCnt;
      end else begin
        checkOutput("sb_ready_without_start", req_ready, 0);
      end
    end
    prevStart = tx_start;
  end

  // Hard stop in case a scenario wedges outside a bounded wait
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int toCycles;
    bit seen;
    rst       = 1'b1;
    enable    = 1'b1;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    req_valid = '0;
    req_data  = '0;

    $display("[TB] reset values");
    resetDut();
    checkResetOutputs("rst");

    $display("[TB] single requester latency");
    applyStimulus(0, 8'hA5, 1'b1);
    tick();
    checkOutput("t1_start", tx_start, 1);
    checkOutput("t1_ready", req_ready, 4'b0001);
    checkOutput("t1_data", tx_data, 8'hA5);
    checkOutput("t1_busy", busy, 1);
    tick();
    checkOutput("t1_start_low", tx_start, 0);
    checkOutput("t1_ready_low", req_ready, 0);
    checkOutput("t1_data_hold", tx_data, 8'hA5);
    repeat (98) tick();
    checkOutput("t1_busy_wait", busy, 1);
    tx_done = 1'b1;
    tick();
    checkOutput("t1_busy_fall", busy, 0);

    $display("[TB] round robin");
    resetDut();
    autoDone  = 1'b1;
    doneDelay = 20;
    spacingOn = 1'b1;
    lastStart = -1;
    for (int i = 0; i < N; i++) begin
      applyStimulus(i, 8'h10 + 8'(8'h11 * i), 1'b0);
      applyStimulus(i, 8'h14 + 8'(8'h11 * i), 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        expectGrant(i, (r == 0 ? 8'h10 : 8'h14) + 8'(8'h11 * i));
      end
    end
    waitDrain(400);
    spacingOn = 1'b0;

    $display("[TB] tx_busy blocks grants");
    resetDut();
    autoDone  = 1'b1;
    doneDelay = 5;
    tx_busy   = 1'b1;
    applyStimulus(2, 8'h77, 1'b0);
    repeat (10) tick();
    checkOutput("t3_busy_blocked", busy, 0);
    tx_busy = 1'b0;
    expectGrant(2, 8'h77);
    tick();
    checkOutput("t3_grant_start", tx_start, 1);
    checkOutput("t3_grant_id", grant_id, 2);
    waitDrain(50);

    $display("[TB] enable low blocks grants");
    resetDut();
    autoDone  = 1'b1;
    doneDelay = 5;
    enable    = 1'b0;
    applyStimulus(1, 8'h5A, 1'b0);
    repeat (15) tick();
    checkOutput("t3_enable_busy", busy, 0);
    checkOutput("t3_enable_id", grant_id, 0);
    enable = 1'b1;
    expectGrant(1, 8'h5A);
    waitDrain(50);

    $display("[TB] tx_done collisions");
    resetDut();
    applyStimulus(3, 8'hC3, 1'b1);
    tick();
    checkOutput("t4_start", tx_start, 1);
    tx_done = 1'b1;
    tick();
    checkOutput("t4_launch_done_ignored", busy, 1);
    repeat (3) tick();
    checkOutput("t4_still_wait", busy, 1);
    tx_done = 1'b1;
    applyStimulus(0, 8'h3C, 1'b1);
    tick();
    checkOutput("t4_idle_busy", busy, 0);
    checkOutput("t4_idle_nostart", tx_start, 0);
    tick();
    checkOutput("t4_next_start", tx_start, 1);
    checkOutput("t4_next_id", grant_id, 0);
    tick();
    tx_done = 1'b1;
    tick();
    checkOutput("t4_final_busy", busy, 0);

    $display("[TB] reset during WAIT");
    resetDut();
    applyStimulus(2, 8'h99, 1'b1);
    tick();
    tick();
    checkOutput("t5_wait_busy", busy, 1);
    rst = 1'b1;
    applyStimulus(3, 8'h33, 1'b0);
    applyStimulus(1, 8'h11, 1'b0);
    autoDone  = 1'b1;
    doneDelay = 4;
    tick();
    rst = 1'b0;
    checkResetOutputs("t5");
    expectGrant(1, 8'h11);
    expectGrant(3, 8'h33);
    waitDrain(100);

`ifdef UART_ARB_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    resetDut();
    applyStimulus(0, 8'hE1, 1'b1);
    applyStimulus(1, 8'hE2, 1'b0);
    tick();
    checkOutput("t6_start", tx_start, 1);
    toCycles = 0;
    seen     = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      toCycles++;
      if (timeout_err) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("t6_timeout_seen", seen, 1);
    checkOutput("t6_timeout_cycles", toCycles, 51);
    checkOutput("t6_busy_after", busy, 0);
    autoDone  = 1'b1;
    doneDelay = 3;
    expectGrant(1, 8'hE2);
    tick();
    checkOutput("t6_pulse_width", timeout_err, 0);
    checkOutput("t6_next_start", tx_start, 1);
    checkOutput("t6_next_id", grant_id, 1);
    waitDrain(50);
`else
    $display("[TB] no watchdog in default build");
    resetDut();
    applyStimulus(0, 8'hE1, 1'b1);
    tick();
    checkOutput("t6_start", tx_start, 1);
    seen     = 1'b0;
    toCycles = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      toCycles++;
      if (timeout_err) seen = 1'b1;
    end
    checkOutput("t6_no_timeout", seen, 0);
    checkOutput("t6_still_busy", busy, 1);
    tx_done = 1'b1;
    tick();
    checkOutput("t6_busy_after", busy, 0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmitter among `N_REQ` byte requesters (APB register path, DMA, debug console, etc.). It captures one byte from the granted requester and drives the UART TX `tx_start`/`tx_data` inputs. It then holds off further grants until the transmitter reports `tx_done`. It sits between the requesters and the UART TX core, alongside the APB UART slave, in the `pclk` domain.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 65535: WAIT-state watchdog limit (16-bit). Used only with `UART_ARB_TIMEOUT_EN`.
- `pclk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  grants allowed when 1. A frame already in flight always completes.
- `req_valid`  in  N_REQ  per-requester byte available.
- `req_data`  in  8*N_REQ  requester i byte at `[8i+7:8i]`.
- `req_ready`  out  N_REQ  one-hot, one-cycle accept pulse.
- `tx_start`  out  1  one-cycle start pulse to UART TX.
- `tx_data`  out  8  byte to UART TX. Held stable from LAUNCH until the next grant.
- `tx_busy`  in  1  UART TX busy.
- `tx_done`  in  1  UART TX frame-complete pulse.
- `grant_id`  out  $clog2(N_REQ)  index of the last/current grant.
- `busy`  out  1  1 in LAUNCH or WAIT.
- `timeout_err`  out  1  one-cycle watchdog pulse. Constant 0 without the macro.

## Operation
- States:
  - IDLE: grant on `enable && |req_valid && !tx_busy` → LAUNCH.
  - LAUNCH: → WAIT unconditionally.
  - WAIT: → IDLE on `tx_done` (or on timeout).
- Round-robin: search starts at pointer `ptr`, ascending with wrap. The first valid index g wins.
  - On grant, `ptr <= (g+1) mod N_REQ`.
  - Reset `ptr=0`.
- On the grant edge, all of the following are registered together:
  - `tx_data <= req_data[g]`
  - `grant_id <= g`
  - `req_ready[g] <= 1`
  - `tx_start <= 1`
- Requester handshake:
  - Hold `req_valid` and data stable until `req_ready` is seen.
  - Deassert or present the next byte the cycle after `req_ready`.
  - Dropping `req_valid` before `req_ready` is a protocol violation. A byte already captured is still sent.
- `tx_done` is only honoured in WAIT. In IDLE and LAUNCH it is ignored.
- `tx_busy` high in IDLE blocks grants. This covers the case where another master is using the TX core.
- `enable` deasserted in LAUNCH/WAIT: the current frame finishes, then the block stays in IDLE.
- Reset mid-frame: return to IDLE immediately, with all outputs at reset values. The UART TX core is not aborted by this block.

## Timing
- Reset values:
  - `req_ready=0`, `tx_start=0`, `tx_data=8'h00`
  - `grant_id=0`, `busy=0`, `timeout_err=0`
  - state IDLE, `ptr=0`
- Grant latency: `req_valid` sampled high at edge k (IDLE) → `req_ready` and `tx_start` high during cycle k+1 (LAUNCH), for exactly one cycle.
- `busy` is high from cycle k+1 until the cycle after `tx_done` is sampled in WAIT.
- `tx_done` sampled at edge m in WAIT → IDLE in cycle m+1. The earliest next grant is sampled at edge m+1, so `tx_start` at m+2.
- Minimum spacing between `tx_start` pulses is 3 cycles plus the frame time.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `tx_done`: `timeout_err` pulses for one cycle, the state goes to IDLE, and `ptr` stays as already advanced.
- Undefined: no counter, WAIT waits indefinitely, and `timeout_err` is tied 0.

## Test plan
- Single requester: reset, `req_valid=4'b0001`, `req_data[7:0]=8'hA5`.
  - Required: `req_ready[0]` and `tx_start` each high for exactly 1 cycle, one edge later; `tx_data=8'hA5`.
  - Then `tx_done` 100 cycles later → `busy` falls the next cycle.
- Round-robin: `req_valid=4'b1111` held, with `tx_done` 20 cycles after each start.
  - Required grant order: 0,1,2,3,0.
  - Each `tx_data` matches the corresponding requester byte (0x10, 0x21, 0x32, 0x43).
- Blocking:
  - `tx_busy=1` in IDLE with `req_valid=4'b0100` → no grant until `tx_busy` falls, then grant 2.
  - `enable=0` → no grant at all.
- Simultaneous events:
  - `tx_done` during LAUNCH is ignored, and the block remains in WAIT.
  - `tx_done` and a new `req_valid` in the same WAIT cycle → IDLE, then a grant at the next edge.
- Reset mid-WAIT: assert `rst` for 1 cycle → all outputs return to reset values, `ptr=0`, and the next grant goes to the lowest valid index.
- Timeout (macro defined, `TIMEOUT_CYCLES=50`): no `tx_done` after a grant → `timeout_err` pulses 1 cycle after 50 WAIT cycles, the state returns to IDLE, and the next requester is granted.
